// File: rtl/wb_ledstrip_pkg.sv
// Register map, frame FSM states and colour helpers
// shared by the LED strip controller files.
package wb_ledstrip_pkg;

  localparam logic [7:0] REG_CTRL   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;
  localparam logic [7:0] REG_LEN    = 8'd2;
  localparam logic [7:0] REG_BRIGHT = 8'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  // (c*(k+1))>>8 keeps k=255 as identity and k=0 as black
  function automatic logic [7:0] scale8(
    input logic [7:0] c,
    input logic [7:0] k
  );
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, k} + 16'd1);
    return 8'(p >> 8);
  endfunction

  function automatic rgb_t scale_rgb(
    input rgb_t       c,
    input logic [7:0] k
  );
    rgb_t o;
    o.g = scale8(c.g, k);
    o.r = scale8(c.r, k);
    o.b = scale8(c.b, k);
    return o;
  endfunction

endpackage

// File: rtl/wb_ledstrip_if.sv
// Wishbone slave bundle for the LED strip controller.
// Signal names follow the slave's view of the bus.
interface wb_ledstrip_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/ws2812_bit_serializer.sv
// Shifts one 24-bit colour word out MSB first with
// WS2812 high/low bit timing.
module ws2812_bit_serializer #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] word,
  output logic        ready,
  output logic        fin,
  output logic        led_out
);
  localparam int CW = $clog2(TBIT);

  logic          active;
  logic [23:0]   sh;
  logic [4:0]    bitn;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] th;
  logic          bit_end;

  assign th      = sh[23] ? CW'(T1H) : CW'(T0H);
  assign cnt_nx  = cnt + CW'(1);
  assign bit_end = (cnt == CW'(TBIT - 1));
  assign ready   = ~active;
  assign fin     = active & bit_end & (bitn == 5'd23);

  always_ff @(posedge clk) begin
    if (!rst) begin
      active  <= 1'b0;
      sh      <= '0;
      bitn    <= '0;
      cnt     <= '0;
      led_out <= 1'b0;
    end else if (!active) begin
      if (load) begin
        active  <= 1'b1;
        sh      <= word;
        bitn    <= '0;
        cnt     <= '0;
        led_out <= 1'b1;
      end
    end else if (bit_end) begin
      cnt <= '0;
      if (bitn == 5'd23) begin
        active  <= 1'b0;
        led_out <= 1'b0;
      end else begin
        bitn    <= bitn + 5'd1;
        sh      <= {sh[22:0], 1'b0};
        led_out <= 1'b1;
      end
    end else begin
      cnt     <= cnt_nx;
      led_out <= (cnt_nx < th);
    end
  end

endmodule

// File: rtl/wb_ledstrip_ctrl.sv
// Wishbone LED strip controller: register file, frame
// buffer, brightness scaling and frame sequencing.
module wb_ledstrip_ctrl
  import wb_ledstrip_pkg::*;
#(
  parameter int NUM_LEDS = 64,
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int TBIT     = 63,
  parameter int TRESET   = 2500
) (
  input  logic         clk,
  input  logic         rst,
  wb_ledstrip_if.slave wb,
  output logic         led_out,
  output logic         busy,
  output logic         done
);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CW = $clog2(TRESET + 1);
  localparam logic [8:0] NL = 9'(NUM_LEDS);

  state_t        state, nstate;
  logic          ack_q, start_q, auto_q, done_q;
  logic [8:0]    len_q, flen, len_eff;
  logic [7:0]    bright_q, fbright, idx, widx;
  logic [31:0]   dat_q, rdata;
  logic [CW-1:0] lcnt;
  logic [23:0]   mem [0:(1<<AW)-1];
  logic          req, wr, rd, is_buf, buf_ok, reg_wr;
  logic          frame_go, idx_inc, ser_load, set_done;
  logic          last_led, latch_end, ser_ready, ser_fin;
  rgb_t          pix, ser_word;
  logic          unused_bits;

  assign unused_bits = &{1'b0, wb.wb_sel_i,
                         wb.wb_adr_i[31:11], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:24]};

  assign req    = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr     = req & wb.wb_we_i;
  assign rd     = req & ~wb.wb_we_i;
  assign widx   = wb.wb_adr_i[9:2];
  assign is_buf = wb.wb_adr_i[10];
  assign buf_ok = ({1'b0, widx} < NL);
  assign reg_wr = wr & ~is_buf;

  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_q;
  assign wb.wb_dat_o = dat_q;

  assign len_eff = (len_q > NL) ? NL : len_q;
  assign busy    = (state != S_IDLE);
  assign done    = done_q;

  always_comb begin
    rdata = '0;
    if (is_buf) begin
      if (buf_ok) rdata = {8'd0, mem[widx[AW-1:0]]};
    end else begin
      unique case (1'b1)
        widx == REG_CTRL:   rdata[CTRL_AUTO] = auto_q;
        widx == REG_STATUS: begin
          rdata[STAT_BUSY] = busy;
          rdata[STAT_DONE] = done_q;
        end
        widx == REG_LEN:    rdata[8:0] = len_q;
        widx == REG_BRIGHT: rdata[7:0] = bright_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      start_q  <= 1'b0;
      auto_q   <= 1'b0;
      len_q    <= NL;
      bright_q <= 8'hFF;
      done_q   <= 1'b0;
    end else begin
      ack_q   <= req;
      start_q <= reg_wr & (widx == REG_CTRL)
               & wb.wb_dat_i[CTRL_START];
      if (rd) dat_q <= rdata;
      if (reg_wr & (widx == REG_CTRL))
        auto_q <= wb.wb_dat_i[CTRL_AUTO];
      if (reg_wr & (widx == REG_LEN))
        len_q <= wb.wb_dat_i[8:0];
      if (reg_wr & (widx == REG_BRIGHT))
        bright_q <= wb.wb_dat_i[7:0];
      if (set_done)
        done_q <= 1'b1;
      else if (reg_wr & (widx == REG_STATUS)
               & wb.wb_dat_i[STAT_DONE])
        done_q <= 1'b0;
    end
  end

  // Asynchronous read port: a same-edge CPU write still hands the old word to the serializer
  always_ff @(posedge clk) begin
    if (wr & is_buf & buf_ok)
      mem[widx[AW-1:0]] <= wb.wb_dat_i[23:0];
  end

  assign pix       = mem[idx[AW-1:0]];
  assign ser_word  = scale_rgb(pix, fbright);
  assign last_led  = (({1'b0, idx} + 9'd1) == flen);
  assign latch_end = (lcnt == CW'(TRESET - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate   = state;
    frame_go = 1'b0;
    idx_inc  = 1'b0;
    ser_load = 1'b0;
    set_done = 1'b0;
    unique case (state)
      S_IDLE: if (start_q) begin
        frame_go = 1'b1;
        nstate   = (len_eff == 9'd0) ? S_LATCH : S_LOAD;
      end
      S_LOAD: if (ser_ready) begin
        ser_load = 1'b1;
        nstate   = S_SHIFT;
      end
      S_SHIFT: if (ser_fin) begin
        if (last_led) begin
          nstate = S_LATCH;
        end else begin
          idx_inc = 1'b1;
          nstate  = S_LOAD;
        end
      end
      S_LATCH: if (latch_end) begin
        if (auto_q) begin
          frame_go = 1'b1;
          nstate   = (len_eff == 9'd0) ? S_LATCH : S_LOAD;
        end else begin
          set_done = 1'b1;
          nstate   = S_IDLE;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx     <= '0;
      flen    <= '0;
      fbright <= '0;
      lcnt    <= '0;
    end else begin
      if (frame_go) begin
        idx     <= '0;
        flen    <= len_eff;
        fbright <= bright_q;
      end else if (idx_inc) begin
        idx <= idx + 8'd1;
      end
      if ((state != S_LATCH) || latch_end) lcnt <= '0;
      else                                 lcnt <= lcnt + CW'(1);
    end
  end

  ws2812_bit_serializer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .word    (ser_word),
    .ready   (ser_ready),
    .fin     (ser_fin),
    .led_out (led_out)
  );

endmodule

// File: tb/tb_wb_ledstrip_ctrl.sv
// Directed bench for wb_ledstrip_ctrl with shortened bit
// and latch timing; a monitor decodes led_out pulses.
module tb_wb_ledstrip_ctrl;
  localparam int NL  = 64;
  localparam int T0  = 4;
  localparam int T1  = 8;
  localparam int TB  = 12;
  localparam int TR  = 100;
  localparam int LED = 1 + 24 * TB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led_out, busy, done;
  int   ncyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;
  int   hlen[$];
  int   rise[$];
  int   hi = 0;
  logic prev = 1'b0;

  wb_ledstrip_if wb ();

  wb_ledstrip_ctrl #(
    .NUM_LEDS (NL),
    .T0H      (T0),
    .T1H      (T1),
    .TBIT     (TB),
    .TRESET   (TR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wb      (wb),
    .led_out (led_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (led_out === 1'b1) begin
      if (!prev) begin
        rise.push_back(ncyc);
        hi = 0;
      end
      hi++;
    end else if (prev) begin
      hlen.push_back(hi);
    end
    prev = (led_out === 1'b1);
  end

  function automatic logic [23:0] pat(input int i);
    return {8'(i), 8'(i) ^ 8'hA5, 8'(i * 7)};
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [31:0] wd,
                         output logic [31:0] rdv);
    int n;
    @(negedge clk);
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_sel_i = 4'hF;
    wb.wb_dat_i = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wb.wb_ack_o !== 1'b1 && n < 4);
    rdv = wb.wb_dat_o;
    chk_cnt++;
    if (n != 1)
      $display("FAIL wb_ack adr=%h got=%0d exp=1", adr, n);
    else pass_cnt++;
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] t;
    wb_xfer(1'b1, adr, d, t);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'd0, d);
  endtask

  task automatic wait_done(input int lim, output int dc);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    dc = ncyc;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (led_out !== 1'b0) $display("FAIL rst_led got=%b exp=0", led_out);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done);
    else pass_cnt++;
    rst = 1'b1;
    wb_rd(32'h8, r);
    chk_cnt++;
    if (r !== 32'd64) $display("FAIL rst_len got=%0d exp=64", r);
    else pass_cnt++;
    wb_rd(32'hC, r);
    chk_cnt++;
    if (r !== 32'd255) $display("FAIL rst_bright got=%0d exp=255", r);
    else pass_cnt++;
    wb_rd(32'h4, r);
    chk_cnt++;
    if (r !== 32'd0) $display("FAIL rst_status got=%h exp=0", r);
    else pass_cnt++;
    wb_rd(32'h0, r);
    chk_cnt++;
    if (r !== 32'd0) $display("FAIL rst_ctrl got=%h exp=0", r);
    else pass_cnt++;
  endtask

  task automatic test_frame;
    logic [31:0] r;
    logic [47:0] w;
    int n0, dc, bad;
    wb_wr(32'h400, 32'hFF0000);
    wb_wr(32'h404, 32'h000001);
    wb_wr(32'h8, 32'd2);
    hlen.delete();
    rise.delete();
    wb_wr(32'h0, 32'd1);
    n0 = ncyc;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL frame_busy_n got=%b exp=0", busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL frame_busy_n1 got=%b exp=1", busy);
    else pass_cnt++;
    wait_done(2 * LED + TR + 50, dc);
    chk_cnt++;
    if (dc != n0 + 1 + 2 * LED + TR)
      $display("FAIL frame_done_cyc got=%0d exp=%0d", dc - n0, 1 + 2 * LED + TR);
    else pass_cnt++;
    chk_cnt++;
    if (rise.size() != 48)
      $display("FAIL frame_nbits got=%0d exp=48", rise.size());
    else pass_cnt++;
    chk_cnt++;
    if (rise.size() == 0 || rise[0] != n0 + 2)
      $display("FAIL frame_first_rise got=%0d exp=2", rise.size() ? rise[0] - n0 : -1);
    else pass_cnt++;
    w = '0;
    bad = 0;
    foreach (hlen[i]) begin
      w = {w[46:0], hlen[i] == T1};
      if (hlen[i] != T0 && hlen[i] != T1) bad++;
    end
    chk_cnt++;
    if (w !== 48'hFF0000000001 || bad != 0)
      $display("FAIL frame_bits got=%h bad=%0d exp=ff0000000001", w, bad);
    else pass_cnt++;
    chk_cnt++;
    if (rise.size() != 48 || dc - rise[47] != TB + TR)
      $display("FAIL frame_latch got=%0d exp=%0d", rise.size() == 48 ? dc - rise[47] : -1, TB + TR);
    else pass_cnt++;
    wb_wr(32'h4, 32'h2);
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL done_clear got=%b exp=0", done);
    else pass_cnt++;
    wb_rd(32'h4, r);
    chk_cnt++;
    if (r !== 32'd0) $display("FAIL status_after got=%h exp=0", r);
    else pass_cnt++;
  endtask

  task automatic test_bright;
    logic [31:0] r;
    logic [23:0] w;
    int n0, dc;
    wb_wr(32'hC, 32'd127);
    wb_wr(32'h400, 32'h808080);
    wb_wr(32'h8, 32'd1);
    hlen.delete();
    rise.delete();
    wb_wr(32'h0, 32'd1);
    n0 = ncyc;
    wait_done(LED + TR + 50, dc);
    w = '0;
    foreach (hlen[i]) w = {w[22:0], hlen[i] == T1};
    chk_cnt++;
    if (w !== 24'h404040 || hlen.size() != 24)
      $display("FAIL bright_word got=%h n=%0d exp=404040", w, hlen.size());
    else pass_cnt++;
    chk_cnt++;
    if (dc != n0 + 1 + LED + TR)
      $display("FAIL bright_done got=%0d exp=%0d", dc - n0, 1 + LED + TR);
    else pass_cnt++;
    wb_rd(32'h400, r);
    chk_cnt++;
    if (r !== 32'h808080) $display("FAIL bright_rdback got=%h exp=808080", r);
    else pass_cnt++;
    wb_wr(32'h4, 32'h2);
    wb_wr(32'hC, 32'd255);
  endtask

  task automatic test_zero_len;
    int n0, dc;
    wb_wr(32'h8, 32'd0);
    hlen.delete();
    rise.delete();
    wb_wr(32'h0, 32'd1);
    n0 = ncyc;
    wait_done(TR + 50, dc);
    chk_cnt++;
    if (dc != n0 + 1 + TR)
      $display("FAIL zero_done got=%0d exp=%0d", dc - n0, 1 + TR);
    else pass_cnt++;
    chk_cnt++;
    if (rise.size() != 0) $display("FAIL zero_bits got=%0d exp=0", rise.size());
    else pass_cnt++;
    wb_wr(32'h4, 32'h2);
  endtask

  task automatic test_clamp_restart;
    logic [31:0] r;
    logic [23:0] p;
    int n0, dc, bad;
    for (int i = 0; i < NL; i++) wb_wr(32'h400 + 32'(4 * i), {8'd0, pat(i)});
    wb_wr(32'h500, 32'h123456);
    wb_rd(32'h500, r);
    chk_cnt++;
    if (r !== 32'd0) $display("FAIL buf_oob got=%h exp=0", r);
    else pass_cnt++;
    wb_rd(32'h4FC, r);
    chk_cnt++;
    if (r !== {8'd0, pat(63)}) $display("FAIL buf_last got=%h exp=%h", r, pat(63));
    else pass_cnt++;
    wb_rd(32'h10, r);
    chk_cnt++;
    if (r !== 32'd0) $display("FAIL reg_unmapped got=%h exp=0", r);
    else pass_cnt++;
    wb_wr(32'h8, 32'd300);
    wb_rd(32'h8, r);
    chk_cnt++;
    if (r !== 32'd300) $display("FAIL len_rdback got=%0d exp=300", r);
    else pass_cnt++;
    hlen.delete();
    rise.delete();
    wb_wr(32'h0, 32'd1);
    n0 = ncyc;
    repeat (50) @(negedge clk);
    wb_wr(32'h0, 32'd1);
    wait_done(NL * LED + TR + 100, dc);
    chk_cnt++;
    if (dc != n0 + 1 + NL * LED + TR)
      $display("FAIL clamp_done got=%0d exp=%0d", dc - n0, 1 + NL * LED + TR);
    else pass_cnt++;
    chk_cnt++;
    if (hlen.size() != NL * 24)
      $display("FAIL clamp_nbits got=%0d exp=%0d", hlen.size(), NL * 24);
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < NL * 24; k++) begin
      p = pat(k / 24);
      if (k >= hlen.size() || (hlen[k] == T1) != p[23 - k % 24]) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL clamp_bits got=%0d wrong exp=0", bad);
    else pass_cnt++;
    wb_wr(32'h4, 32'h2);
  endtask

  task automatic test_auto;
    int n, dc, d1, lim;
    wb_wr(32'h8, 32'd1);
    hlen.delete();
    rise.delete();
    wb_wr(32'h0, 32'd3);
    n = 0;
    lim = 2 * LED + TR + 50;
    while (rise.size() < 25 && n < lim) begin
      @(negedge clk);
      n++;
    end
    d1 = (rise.size() >= 25) ? rise[24] - rise[0] : -1;
    chk_cnt++;
    if (d1 != LED + TR) $display("FAIL auto_gap got=%0d exp=%0d", d1, LED + TR);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL auto_running got=%b%b exp=10", busy, done);
    else pass_cnt++;
    wb_wr(32'h0, 32'd0);
    wait_done(LED + TR + 50, dc);
    chk_cnt++;
    if (rise.size() < 25 || dc != rise[24] - 1 + LED + TR)
      $display("FAIL auto_stop got=%0d exp=%0d", rise.size() >= 25 ? dc - rise[24] : -1, LED + TR - 1);
    else pass_cnt++;
    repeat (3 * TB) @(negedge clk);
    chk_cnt++;
    if (rise.size() != 48 || busy !== 1'b0)
      $display("FAIL auto_no_third got=%0d busy=%b exp=48", rise.size(), busy);
    else pass_cnt++;
    wb_wr(32'h4, 32'h2);
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int n;
    wb_wr(32'h8, 32'd2);
    rise.delete();
    wb_wr(32'h0, 32'd1);
    n = 0;
    while (!(rise.size() >= 3 && led_out === 1'b1) && n < LED) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (led_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_rst got=%b%b exp=00", led_out, busy);
    else pass_cnt++;
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk_cnt++;
    if (led_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_rst_idle got=%b%b exp=00", led_out, busy);
    else pass_cnt++;
    wb_rd(32'h400, r);
    chk_cnt++;
    if (r !== {8'd0, pat(0)}) $display("FAIL mid_rst_buf got=%h exp=%h", r, pat(0));
    else pass_cnt++;
    wb_rd(32'h8, r);
    chk_cnt++;
    if (r !== 32'd64) $display("FAIL mid_rst_len got=%0d exp=64", r);
    else pass_cnt++;
  endtask

  initial begin
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = '0;
    wb.wb_sel_i = '0;
    wb.wb_dat_i = '0;
    test_reset();
    test_frame();
    test_bright();
    test_zero_len();
    test_clamp_restart();
    test_auto();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
